// File: rtl/dmem_access.sv
// -----------------------------------------------------------------------------
// dmem_access
//
// Data-memory access unit. Takes one load/store request at a time from the MEM
// stage, runs it on a 64-bit request/grant/rvalid bus and returns a single-cycle
// response. Loads are extracted from the addressed byte lane and sign- or
// zero-extended to 64 bits; stores are lane-shifted with matching byte enables.
// Illegal encodings, misalignment (when trapped) and bus timeouts are reported
// through resp_err in the same response pulse.
//
// Configuration macro:
//   DMEM_MISALIGN_TRAP_EN  defined   -> misaligned accesses respond with error
//                                       immediately and never reach the bus.
//                          undefined -> misaligned addresses are aligned down
//                                       to the access size and proceed.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   req_valid/req_ready   request handshake from MEM stage (ready only in IDLE)
//   rd_ctrl, wr_ctrl      load / store type encodings from decode
//   addr, wdata           byte address and LSB-aligned store data
//   resp_valid            one-cycle completion pulse
//   rdata, resp_err       extended load data and error flag for the response
//   mem_req/mem_gnt       bus request (held until grant) and grant
//   mem_we, mem_addr      store flag and dword-aligned bus address
//   mem_wdata, mem_be     lane-shifted store data and byte enables
//   mem_rvalid, mem_rdata load data return
// -----------------------------------------------------------------------------
module dmem_access #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        rd_ctrl,
    input  logic [2:0]        wr_ctrl,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wdata,
    output logic              resp_valid,
    output logic [63:0]       rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       rd_q;
    logic [2:0]       off_q;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;

    // Decode of the request currently presented on the input side.
    logic       dec_noop;
    logic       dec_err;
    logic       dec_store;
    logic [1:0] dec_size;   // 0 byte, 1 half, 2 word, 3 dword
    logic [2:0] dec_mask;   // address bits that must be zero for this size
    logic [2:0] dec_off;
    logic       dec_illegal;

    function automatic logic [7:0] byte_enables(input logic [1:0] size,
                                                input logic [2:0] off);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    function automatic logic [63:0] load_extract(input logic [2:0]  rd,
                                                 input logic [2:0]  off,
                                                 input logic [63:0] data);
        logic [63:0] sh;
        logic [63:0] res;
        sh = data >> {off, 3'b000};
        case (rd)
            3'b001:  res = {{56{sh[7]}},  sh[7:0]};
            3'b010:  res = {56'd0,        sh[7:0]};
            3'b011:  res = {{48{sh[15]}}, sh[15:0]};
            3'b100:  res = {48'd0,        sh[15:0]};
            3'b101:  res = {{32{sh[31]}}, sh[31:0]};
            3'b110:  res = sh;
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    always_comb begin
        dec_size = 2'd0;
        case (rd_ctrl)
            3'b011, 3'b100: dec_size = 2'd1;
            3'b101:         dec_size = 2'd2;
            3'b110:         dec_size = 2'd3;
            default: begin
                case (wr_ctrl)
                    3'b010:  dec_size = 2'd1;
                    3'b011:  dec_size = 2'd2;
                    3'b100:  dec_size = 2'd3;
                    default: dec_size = 2'd0;
                endcase
            end
        endcase

        case (dec_size)
            2'd0:    dec_mask = 3'b000;
            2'd1:    dec_mask = 3'b001;
            2'd2:    dec_mask = 3'b011;
            default: dec_mask = 3'b111;
        endcase

        dec_store   = (wr_ctrl != 3'b000);
        dec_noop    = (rd_ctrl == 3'b000) && (wr_ctrl == 3'b000);
        // Both controls set, or a reserved encoding on either side.
        dec_illegal = (rd_ctrl == 3'b111) || (wr_ctrl > 3'b100) ||
                      ((rd_ctrl != 3'b000) && (wr_ctrl != 3'b000));
`ifdef DMEM_MISALIGN_TRAP_EN
        dec_err = dec_illegal || ((addr[2:0] & dec_mask) != 3'b000);
        dec_off = addr[2:0];
`else
        dec_err = dec_illegal;
        dec_off = addr[2:0] & ~dec_mask;
`endif
    end

    // The timeout fires in the TIMEOUT_CYCLES-th cycle spent in REQ+WAIT.
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = (dec_noop || dec_err) ? RESP : REQ;
                end
            end
            REQ: begin
                // A grant in the last allowed cycle still completes normally.
                if (mem_gnt) begin
                    state_nxt = mem_we ? RESP : WAIT;
                end else if (timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            WAIT: begin
                if (mem_rvalid || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        req_ready  = (state == IDLE);
        mem_req    = (state == REQ);
        resp_valid = (state == RESP);
    end

    // Request capture, bus fields, counter and response data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_be    <= 8'h00;
            mem_addr  <= '0;
            mem_wdata <= 64'd0;
            resp_err  <= 1'b0;
            rdata     <= 64'd0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mem_addr  <= {addr[ADDR_W-1:3], 3'b000};
                        mem_we    <= dec_store;
                        mem_be    <= byte_enables(dec_size, dec_off);
                        mem_wdata <= wdata << {dec_off, 3'b000};
                        resp_err  <= dec_err;
                        rdata     <= 64'd0;
                        cnt       <= '0;
                    end
                end
                REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (!mem_gnt && timeout_hit) begin
                        resp_err <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem_rvalid) begin
                        rdata <= load_extract(rd_q, off_q, mem_rdata);
                    end else if (timeout_hit) begin
                        resp_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Load type and lane offset are only needed for extraction; no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            rd_q  <= rd_ctrl;
            off_q <= dec_off;
        end
    end

endmodule

// File: tb/tb_dmem_access.sv
`timescale 1ns/1ps
module tb_dmem_access;

    localparam int ADDR_W = 32;
    localparam int TO     = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  rd_ctrl;
    logic [2:0]  wr_ctrl;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        resp_valid;
    logic [63:0] rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_access #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .rd_ctrl(rd_ctrl), .wr_ctrl(wr_ctrl), .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .rdata(rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        string       name;
        logic [2:0]  rd;
        logic [2:0]  wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] bus_rdata;
        bit          bus;        // a bus cycle is expected
        logic [7:0]  be;
        logic [31:0] maddr;
        logic [63:0] mwdata;
        logic [63:0] rdata;
        logic        err;
        int          gnt_dly;    // REQ cycles before grant, <0 = never
        int          rv_dly;     // WAIT cycles before rvalid, <0 = never
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", what, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [2:0] rd, input logic [2:0] wr,
                                input logic [31:0] a, input logic [63:0] wd,
                                input logic [63:0] brd, input bit bus, input logic [7:0] be,
                                input logic [31:0] ma, input logic [63:0] mwd,
                                input logic [63:0] rdv, input logic err,
                                input int gd, input int rvd);
        vec_t v;
        v.name = nm; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd;
        v.bus_rdata = brd; v.bus = bus; v.be = be; v.maddr = ma; v.mwdata = mwd;
        v.rdata = rdv; v.err = err; v.gnt_dly = gd; v.rv_dly = rvd;
        return v;
    endfunction

    // Drive one request, act as the bus slave, and check the response.
    task automatic run_vec(input vec_t v, output int req_cnt);
        exp_t e;
        exp_t got;
        int   wait_rdy;
        int   wait_cycles;
        int   bus_bad;
        bit   gnt_given;
        bit   done;
        bit   saw_req;
        bit   is_load;

        wait_rdy = 0;
        @(negedge clk);
        while (!req_ready && wait_rdy < 10) begin
            @(negedge clk);
            wait_rdy++;
        end
        check({v.name, " req_ready"}, 64'(req_ready), 64'd1);

        rd_ctrl   = v.rd;
        wr_ctrl   = v.wr;
        addr      = v.addr;
        wdata     = v.wdata;
        req_valid = 1'b1;

        is_load = (v.wr == 3'b000);
        e.rdata = v.rdata;
        e.err   = v.err;
        if (!v.bus)                e.lat = 1;
        else if (v.gnt_dly < 0)    e.lat = TO + 1;
        else if (!is_load)         e.lat = 2 + v.gnt_dly;
        else if (v.rv_dly < 0)     e.lat = TO + 1;
        else                       e.lat = 3 + v.gnt_dly + v.rv_dly;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rd_ctrl   = 3'b000;
        wr_ctrl   = 3'b000;
        addr      = $urandom;
        wdata     = {$urandom, $urandom};

        req_cnt     = 0;
        wait_cycles = 0;
        bus_bad     = 0;
        gnt_given   = 1'b0;
        done        = 1'b0;
        saw_req     = 1'b0;
        for (int c = 1; c <= TO + 20 && !done; c++) begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = {$urandom, $urandom};
            if (resp_valid) begin
                done = 1'b1;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL %s unexpected_resp: got response, expected none", v.name);
                end else begin
                    got = sb_q.pop_front();
                    check({v.name, " resp_err"}, 64'(resp_err), 64'(got.err));
                    check({v.name, " rdata"},    rdata,          got.rdata);
                    check({v.name, " latency"},  64'(c),         64'(got.lat));
                end
                check({v.name, " mem_req_at_resp"}, 64'(mem_req), 64'd0);
            end else if (mem_req) begin
                if (!saw_req) begin
                    check({v.name, " mem_addr"}, 64'(mem_addr), 64'(v.maddr));
                    check({v.name, " mem_be"},   64'(mem_be),   64'(v.be));
                    check({v.name, " mem_we"},   64'(mem_we),   64'(!is_load));
                    if (!is_load) check({v.name, " mem_wdata"}, mem_wdata, v.mwdata);
                end
                if (mem_addr !== v.maddr || mem_be !== v.be || mem_we !== !is_load ||
                    (!is_load && mem_wdata !== v.mwdata)) bus_bad++;
                saw_req = 1'b1;
                if (v.gnt_dly >= 0 && req_cnt == v.gnt_dly) begin
                    mem_gnt   = 1'b1;
                    gnt_given = 1'b1;
                end
                req_cnt++;
            end else if (gnt_given && is_load) begin
                if (v.rv_dly >= 0 && wait_cycles == v.rv_dly) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = v.bus_rdata;
                end
                wait_cycles++;
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s no_resp: got no resp_valid, expected one within %0d cycles", v.name, TO + 20);
        end
        check({v.name, " bus_used"},   64'(saw_req), 64'(v.bus));
        check({v.name, " bus_stable"}, 64'(bus_bad), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rc;
        int   stray;
        vec_t v;

        rst_n = 1'b0; req_valid = 1'b0; rd_ctrl = 3'b000; wr_ctrl = 3'b000;
        addr = 32'd0; wdata = 64'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;

        //          name       rd      wr      addr          wdata                   bus_rdata               bus be     maddr         mwdata                  rdata                   err gd rv
        vecs.push_back(mk("lb",   3'b001, 3'b000, 32'h0000_1003, 64'd0,                  64'h0000_0000_8000_0000, 1, 8'h08, 32'h0000_1000, 64'd0,                  64'hFFFF_FFFF_FFFF_FF80, 0, 0, 0));
        vecs.push_back(mk("lbu",  3'b010, 3'b000, 32'h0000_1003, 64'd0,                  64'h0000_0000_8000_0000, 1, 8'h08, 32'h0000_1000, 64'd0,                  64'h0000_0000_0000_0080, 0, 1, 2));
        vecs.push_back(mk("sh",   3'b000, 3'b010, 32'h0000_2006, 64'h0000_0000_0000_BEEF, 64'd0,                  1, 8'hC0, 32'h0000_2000, 64'hBEEF_0000_0000_0000, 64'd0,                  0, 0, 0));
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs.push_back(mk("lw_mis", 3'b101, 3'b000, 32'h0000_4002, 64'd0,                64'h1234_5678_9ABC_DEF0, 0, 8'h0F, 32'h0000_4000, 64'd0,                  64'd0,                  1, 0, 0));
`else
        vecs.push_back(mk("lw_mis", 3'b101, 3'b000, 32'h0000_4002, 64'd0,                64'h1234_5678_9ABC_DEF0, 1, 8'h0F, 32'h0000_4000, 64'd0,                  64'hFFFF_FFFF_9ABC_DEF0, 0, 0, 0));
`endif
        vecs.push_back(mk("both", 3'b001, 3'b011, 32'h0000_0010, 64'd0,                  64'd0,                  0, 8'h00, 32'h0,         64'd0,                  64'd0,                  1, 0, 0));
        vecs.push_back(mk("wr110",3'b000, 3'b110, 32'h0000_0010, 64'd0,                  64'd0,                  0, 8'h00, 32'h0,         64'd0,                  64'd0,                  1, 0, 0));
        vecs.push_back(mk("rd111",3'b111, 3'b000, 32'h0000_0010, 64'd0,                  64'd0,                  0, 8'h00, 32'h0,         64'd0,                  64'd0,                  1, 0, 0));
        vecs.push_back(mk("noop", 3'b000, 3'b000, 32'h0000_0010, 64'd0,                  64'd0,                  0, 8'h00, 32'h0,         64'd0,                  64'd0,                  0, 0, 0));
        vecs.push_back(mk("lh",   3'b011, 3'b000, 32'h0000_5002, 64'd0,                  64'h0000_0000_8001_0000, 1, 8'h0C, 32'h0000_5000, 64'd0,                  64'hFFFF_FFFF_FFFF_8001, 0, 0, 1));
        vecs.push_back(mk("lhu",  3'b100, 3'b000, 32'h0000_5006, 64'd0,                  64'hABCD_0000_0000_0000, 1, 8'hC0, 32'h0000_5000, 64'd0,                  64'h0000_0000_0000_ABCD, 0, 2, 0));
        vecs.push_back(mk("lw",   3'b101, 3'b000, 32'h0000_6004, 64'd0,                  64'h8765_4321_0000_0000, 1, 8'hF0, 32'h0000_6000, 64'd0,                  64'hFFFF_FFFF_8765_4321, 0, 0, 0));
        vecs.push_back(mk("ld",   3'b110, 3'b000, 32'h0000_7000, 64'd0,                  64'hDEAD_BEEF_CAFE_F00D, 1, 8'hFF, 32'h0000_7000, 64'd0,                  64'hDEAD_BEEF_CAFE_F00D, 0, 0, 3));
        vecs.push_back(mk("sb",   3'b000, 3'b001, 32'h0000_8005, 64'h0000_0000_0000_00A5, 64'd0,                  1, 8'h20, 32'h0000_8000, 64'h0000_A500_0000_0000, 64'd0,                  0, 3, 0));
        vecs.push_back(mk("sw",   3'b000, 3'b011, 32'h0000_9004, 64'h0000_0000_1122_3344, 64'd0,                  1, 8'hF0, 32'h0000_9000, 64'h1122_3344_0000_0000, 64'd0,                  0, 0, 0));
        vecs.push_back(mk("sd",   3'b000, 3'b100, 32'h0000_A000, 64'h0102_0304_0506_0708, 64'd0,                  1, 8'hFF, 32'h0000_A000, 64'h0102_0304_0506_0708, 64'd0,                  0, 1, 0));
        vecs.push_back(mk("lb7",  3'b001, 3'b000, 32'h0000_B007, 64'd0,                  64'h7F00_0000_0000_0000, 1, 8'h80, 32'h0000_B000, 64'd0,                  64'h0000_0000_0000_007F, 0, 0, 0));
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs.push_back(mk("sd_mis", 3'b000, 3'b100, 32'h0000_A003, 64'h0102_0304_0506_0708, 64'd0,              0, 8'hFF, 32'h0000_A000, 64'h0102_0304_0506_0708, 64'd0,                  1, 0, 0));
        vecs.push_back(mk("lhu_mis",3'b100, 3'b000, 32'h0000_B001, 64'd0,                64'h0000_0000_0000_1234, 0, 8'h03, 32'h0000_B000, 64'd0,                  64'd0,                  1, 0, 0));
`else
        vecs.push_back(mk("sd_mis", 3'b000, 3'b100, 32'h0000_A003, 64'h0102_0304_0506_0708, 64'd0,              1, 8'hFF, 32'h0000_A000, 64'h0102_0304_0506_0708, 64'd0,                  0, 0, 0));
        vecs.push_back(mk("lhu_mis",3'b100, 3'b000, 32'h0000_B001, 64'd0,                64'h0000_0000_0000_1234, 1, 8'h03, 32'h0000_B000, 64'd0,                  64'h0000_0000_0000_1234, 0, 0, 0));
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst mem_req",    64'(mem_req),    64'd0);
        check("rst resp_valid", 64'(resp_valid), 64'd0);
        check("rst mem_be",     64'(mem_be),     64'd0);
        check("rst mem_addr",   64'(mem_addr),   64'd0);
        check("rst rdata",      rdata,           64'd0);
        check("rst resp_err",   64'(resp_err),   64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst req_ready", 64'(req_ready), 64'd1);

        // Table-driven vectors
        foreach (vecs[i]) run_vec(vecs[i], rc);

        // Grant never arrives: timeout out of REQ, then a late rvalid is ignored
        v = mk("to_req", 3'b110, 3'b000, 32'h0000_3000, 64'd0, 64'h1111_2222_3333_4444, 1, 8'hFF,
               32'h0000_3000, 64'd0, 64'd0, 1, -1, 0);
        run_vec(v, rc);
        check("to_req req_cycles", 64'(rc), 64'(TO));
        stray = 0;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_gnt    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_gnt    = 1'b0;
            if (resp_valid || mem_req) stray++;
        end
        check("late_rvalid stray", 64'(stray), 64'd0);

        // Grant arrives but rvalid never does: timeout out of WAIT
        v = mk("to_wait", 3'b101, 3'b000, 32'h0000_3004, 64'd0, 64'd0, 1, 8'hF0,
               32'h0000_3000, 64'd0, 64'd0, 1, 0, -1);
        run_vec(v, rc);

        // Reset asserted while waiting for load data
        @(negedge clk);
        rd_ctrl = 3'b101; wr_ctrl = 3'b000; addr = 32'h0000_D004; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; rd_ctrl = 3'b000;
        @(negedge clk);
        check("rstw mem_req", 64'(mem_req), 64'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("rstw in_wait", 64'(mem_req | resp_valid), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstw req_ready",  64'(req_ready),  64'd1);
        check("rstw mem_req",    64'(mem_req),    64'd0);
        check("rstw resp_valid", 64'(resp_valid), 64'd0);
        check("rstw mem_we",     64'(mem_we),     64'd0);
        check("rstw mem_be",     64'(mem_be),     64'd0);
        check("rstw mem_addr",   64'(mem_addr),   64'd0);
        check("rstw mem_wdata",  mem_wdata,       64'd0);
        check("rstw rdata",      rdata,           64'd0);
        check("rstw resp_err",   64'(resp_err),   64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        stray = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (resp_valid) stray++;
        end
        check("rstw stray_resp", 64'(stray), 64'd0);

        // Back-to-back store then load of the same word
        v = mk("b2b_sw", 3'b000, 3'b011, 32'h0000_C004, 64'h0000_0000_CAFE_BABE, 64'd0, 1, 8'hF0,
               32'h0000_C000, 64'hCAFE_BABE_0000_0000, 64'd0, 0, 0, 0);
        run_vec(v, rc);
        v = mk("b2b_lw", 3'b101, 3'b000, 32'h0000_C004, 64'd0, 64'hCAFE_BABE_0000_0000, 1, 8'hF0,
               32'h0000_C000, 64'd0, 64'hFFFF_FFFF_CAFE_BABE, 0, 0, 0);
        run_vec(v, rc);

        check("scoreboard empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_access.md
# dmem_access

Data-memory access unit that consumes the load/store controls produced by instruction decode and executes them on the 64-bit data-memory bus. It accepts one request at a time from the MEM stage and drives a request/grant/rvalid bus. Loads are returned byte/half/word/dword-extracted and sign- or zero-extended to 64 bits. Errors (illegal encoding, misalignment, bus timeout) are reported in the same single-cycle response.

## Interface
Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT_CYCLES, 255, maximum cycles spent in REQ+WAIT before an error response; must be ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- rd_ctrl  in  3  load type: 000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw, 110 ld, 111 illegal.
- wr_ctrl  in  3  store type: 000 none, 001 sb, 010 sh, 011 sw, 100 sd, 101–111 illegal.
- addr  in  ADDR_W  byte address.
- wdata  in  64  store data, LSB-aligned.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- rdata  out  64  extended load data; 0 for stores, no-ops and errors.
- resp_err  out  1  qualifies resp_valid.
- mem_req  out  1  bus request, held until mem_gnt.
- mem_we  out  1  1 = store.
- mem_addr  out  ADDR_W  addr with [2:0] forced to 0.
- mem_wdata  out  64  wdata shifted left by 8*addr[2:0].
- mem_be  out  8  byte enables.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  64  load data.

## Operation
- FSM: IDLE, REQ, WAIT, RESP. Request, offset and type are registered at acceptance (req_valid & req_ready).
- IDLE→REQ on a legal, aligned access. IDLE→RESP directly for: both controls zero (no-op, err=0), both nonzero, illegal encoding, or a trapped misalignment (err=1).
- REQ: mem_req=1. On mem_gnt: store→RESP, load→WAIT.
- WAIT: on mem_rvalid, latch the extracted data and go to RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
- Byte enables: sb 0x01<<off, sh 0x03<<off, sw 0x0F<<off, sd 0xFF, where off=addr[2:0].
- Load extraction: mem_rdata>>(8*off). lb/lh/lw sign-extend from bit 7/15/31. lbu/lhu zero-extend. ld passes through.
- Timeout counter: cleared on entry to REQ and increments each cycle in REQ/WAIT. When it reaches TIMEOUT_CYCLES without completion, go to RESP with err=1 and drop mem_req.
- mem_gnt or mem_rvalid seen outside REQ/WAIT is ignored. A late rvalid after a timeout is discarded.
- Reset (any state, mid-transaction included): next edge returns to IDLE. Reset values: mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_err=0, rdata=0, counter=0. req_ready=1 from the first cycle after reset release.

## Timing
- Request accepted at edge N; mem_req is high in cycle N+1 (registered outputs).
- Earliest store completion: gnt in N+1, resp_valid in N+2, req_ready in N+3.
- Earliest load completion: gnt in N+1, rvalid in N+2, resp_valid in N+3.
- Immediate responses (no-op/error): resp_valid in N+1.
- mem_addr, mem_we, mem_be and mem_wdata are stable for the whole time mem_req is high.
- Throughput: one access per 3 cycles minimum for stores, 4 for loads.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: a misaligned access (lh/lhu/sh with addr[0]≠0; lw/sw with addr[1:0]≠0; ld/sd with addr[2:0]≠0) gets resp_err=1 at N+1 and no bus cycle.
- Not defined: the offending low address bits are cleared (aligned down to the access size) and the access proceeds normally with err=0.

## Test plan
- lb at 0x1003, mem_rdata=0x0000_0000_8000_0000: mem_be=0x08, resp rdata=0xFFFF_FFFF_FFFF_FF80. The same access as lbu returns 0x80.
- sh at 0x2006, wdata=0xBEEF, gnt in first REQ cycle: mem_be=0xC0, mem_wdata[63:48]=0xBEEF, mem_addr=0x2000, resp_valid exactly 2 cycles after accept, err=0.
- ld at 0x3000, mem_gnt held low: mem_req stays high, resp_err=1 after 255 cycles, mem_req drops the same edge. A later mem_rvalid produces no response.
- lw at 0x4002: with macro, err=1 at N+1 and mem_req never asserts. Without macro, mem_addr=0x4000, mem_be=0x0F, err=0.
- rd_ctrl=001 and wr_ctrl=011 together, then wr_ctrl=110: both give resp_err=1 at N+1 and no mem_req.
- rst_n low during WAIT: the next cycle is IDLE with all outputs at reset values. A back-to-back sw/lw pair afterwards completes with correct data.
